// File: rtl/mod_n_counter_pkg.sv
// Shared clock-datapath definitions for the digit counters.
// Direction encodings and width helper.
package clock_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_n_counter_if.sv
// Control/data bundle between a digit counter and its driver.
// Master drives controls; slave returns count and carry.
interface mod_n_counter_if #(
  parameter int WIDTH = 2
);
  logic             EN;
  logic             DIR;
  logic             incre;
  logic             decre;
  logic             load;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             CO;

  modport master (
    output EN, DIR, incre, decre, load, D,
    input  Q, CO
  );

  modport slave (
    input  EN, DIR, incre, decre, load, D,
    output Q, CO
  );
endinterface

// File: rtl/mod_n_counter_key_pulse.sv
// Two-flop synchroniser plus rising-edge detector for set keys.
// One pulse per low-to-high transition of key.
module key_pulse (
  input  logic CP,
  input  logic reset,
  input  logic key,
  output logic pulse
);
  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge CP or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= key;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign pulse = s2 & ~prev;
endmodule

// File: rtl/mod_n_counter.sv
// Modulo-N up/down digit counter with load, set keys and
// cascadable carry/borrow.
module mod_n_counter
  import clock_pkg::*;
#(
  parameter int MODULUS   = 3,
  parameter int WIDTH     = 2,
  parameter int INIT      = 0,
  parameter int SYNC_KEYS = 1
) (
  input  logic CP,
  input  logic reset,
  mod_n_counter_if.slave bus
);
  localparam int W1 = WIDTH + 1;
  localparam logic [WIDTH:0] MAXV = W1'(MODULUS - 1);
  localparam int INIT_I =
    (INIT >= MODULUS) ? MODULUS - 1 : INIT;
  localparam logic [WIDTH:0] INIT_V = W1'(INIT_I);

  logic up_p;
  logic dn_p;

  generate
    if (SYNC_KEYS != 0) begin : g_sync
      key_pulse u_up (
        .CP    (CP),
        .reset (reset),
        .key   (bus.incre),
        .pulse (up_p)
      );
      key_pulse u_dn (
        .CP    (CP),
        .reset (reset),
        .key   (bus.decre),
        .pulse (dn_p)
      );
    end else begin : g_raw
      assign up_p = bus.incre;
      assign dn_p = bus.decre;
    end
  endgenerate

  // One spare top bit so Q+1 at all-ones cannot alias to 0.
  logic [WIDTH:0] q;
  logic [WIDTH:0] nx;
  logic [WIDTH:0] dx;
  logic [WIDTH:0] inc;
  logic [WIDTH:0] dec;
  logic           step_any;
  logic           do_load;
  logic           do_step;
  logic           do_cnt;
  logic           term;

  assign dx  = {1'b0, bus.D};
  assign inc = (q == MAXV) ? '0 : q + W1'(1);
  assign dec = (q == '0) ? MAXV : q - W1'(1);

  assign step_any = up_p | dn_p;
  assign do_load  = bus.load;
  assign do_step  = ~bus.load & step_any;
  assign do_cnt   = ~bus.load & ~step_any & bus.EN;

  always_comb begin
    nx = q;
    unique case (1'b1)
      do_load: nx = (dx > MAXV) ? MAXV : dx;
      do_step: begin
        if (up_p & ~dn_p)
          nx = inc;
        else if (dn_p & ~up_p)
          nx = dec;
      end
      do_cnt:
        nx = (bus.DIR == DIR_DOWN) ? dec : inc;
      default: nx = q;
    endcase
  end

  always_ff @(posedge CP or negedge reset) begin
    if (!reset)
      q <= INIT_V;
    else
      q <= nx;
  end

  assign term = (bus.DIR == DIR_UP) ?
    (q == MAXV) : (q == '0);

  assign bus.Q  = q[WIDTH-1:0];
  assign bus.CO = reset & bus.EN & ~bus.load &
                  ~step_any & term;
endmodule
